round_robin_request_queues: RTL and testbench

Upstream stage of the two-requester round-robin arbiter. Buffers two independent producer streams in small per-channel FIFOs and drives the arbiter's 2-bit `requests` vector from FIFO non-empty status. It consumes the arbiter's same-cycle `grants` to pop the granted head and present it, with its channel id, on a single registered output.

---
 rtl/rr_queue_pkg.sv | 20 ++
 rtl/request_queue_fifo.sv | 79 +++++++
 rtl/round_robin_request_queues.sv | 111 +++++++++++
 tb/tb_round_robin_request_queues.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_queue_pkg.sv
// Shared definitions for the two-channel request queue front end of the
// round-robin arbiter: channel count, channel id type and grant helpers.
package rr_queue_pkg;

  localparam int CH_COUNT = 2;

  typedef logic ch_id_t;

  // A grant vector with every bit set can never come from a healthy
  // arbiter; such a vector is treated as an error and pops nothing.
  function automatic logic grantLegal(input logic [CH_COUNT-1:0] grantVec);
    return grantVec != '1;
  endfunction

  // Channel index of a legal one-hot grant (channel 0 when no bit is set).
  function automatic ch_id_t grantIndex(input logic [CH_COUNT-1:0] grantVec);
    return ch_id_t'(grantVec[1]);
  endfunction

endpackage

// File: rtl/request_queue_fifo.sv
// Single-channel request FIFO. Storage is a small register array with
// wrapping read/write pointers and an explicit occupancy count, so that
// full and empty come straight from registered state. The head entry is
// read combinationally so the consumer can register it on the pop edge.
module request_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A push into a full FIFO is refused even when a pop frees a slot in the
  // same cycle; a pop from an empty FIFO is ignored.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  assign head_data = mem_q[rdPtr_q];

  // Next pointer and occupancy values; DEPTH is a power of two so the
  // pointers wrap naturally from DEPTH-1 back to 0.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are only meaningful below the count, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data;
    end
  end

endmodule

// File: rtl/round_robin_request_queues.sv
// Front end of the two-requester round-robin arbiter. Each producer stream
// is buffered in its own FIFO; FIFO non-empty status forms the request
// vector, and the arbiter's same-cycle grant pops the chosen head into a
// single registered output tagged with its channel id.
module round_robin_request_queues
  import rr_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in0_valid,
  input  logic [WIDTH-1:0]    in0_data,
  output logic                in0_ready,
  input  logic                in1_valid,
  input  logic [WIDTH-1:0]    in1_data,
  output logic                in1_ready,
  output logic [CH_COUNT-1:0] requests,
  input  logic [CH_COUNT-1:0] grants,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_id,
  output logic                grant_error
);

  logic [CH_COUNT-1:0] fifoEmpty;
  logic [CH_COUNT-1:0] fifoFull;
  logic [CH_COUNT-1:0] popReq;
  logic [WIDTH-1:0]    head0;
  logic [WIDTH-1:0]    head1;
  logic                grantsOk;

  logic                outValid_q, outValid_d;
  logic [WIDTH-1:0]    outData_q, outData_d;
  ch_id_t              outId_q, outId_d;
  logic                grantError_q, grantError_d;

  // Requests depend only on registered FIFO occupancy, never on the
  // producer valids, so there is no combinational loop through the arbiter.
  assign requests  = ~fifoEmpty;
  assign in0_ready = !fifoFull[0];
  assign in1_ready = !fifoFull[1];

  // A grant pops only a channel that is actually requesting; a grant on an
  // empty channel is silently dropped and the all-ones pattern pops nothing.
  assign grantsOk = grantLegal(grants);
  assign popReq   = grantsOk ? (grants & requests) : '0;

  request_queue_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (in0_valid && in0_ready),
    .push_data (in0_data),
    .pop       (popReq[0]),
    .head_data (head0),
    .empty     (fifoEmpty[0]),
    .full      (fifoFull[0])
  );

  request_queue_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (in1_valid && in1_ready),
    .push_data (in1_data),
    .pop       (popReq[1]),
    .head_data (head1),
    .empty     (fifoEmpty[1]),
    .full      (fifoFull[1])
  );

  // Select the popped head for the output register; payload and id hold
  // their last values on cycles with no pop.
  always_comb begin
    outValid_d   = |popReq;
    outData_d    = outData_q;
    outId_d      = outId_q;
    grantError_d = !grantsOk;
    if (|popReq) begin
      outId_d   = grantIndex(popReq);
      outData_d = popReq[1] ? head1 : head0;
    end
  end

  // Output and error registers; reset clears any pending output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outId_q      <= 1'b0;
      grantError_q <= 1'b0;
    end else begin
      outValid_q   <= outValid_d;
      outData_q    <= outData_d;
      outId_q      <= outId_d;
      grantError_q <= grantError_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_data    = outData_q;
  assign out_id      = outId_q;
  assign grant_error = grantError_q;

endmodule

// File: tb/tb_round_robin_request_queues.sv
// Bench for round_robin_request_queues: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based model of the two channels.
module tb_round_robin_request_queues;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic [1:0]       requests;
  logic [1:0]       grants;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             grant_error;

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       expOutValid;
  logic [7:0] expOutData;
  logic       expOutId;
  logic       expGrantErr;
  bit         arbTurn;

  round_robin_request_queues #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in0_valid   (in0_valid),
    .in0_data    (in0_data),
    .in0_ready   (in0_ready),
    .in1_valid   (in1_valid),
    .in1_data    (in1_data),
    .in1_ready   (in1_ready),
    .requests    (requests),
    .grants      (grants),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .grant_error (grant_error)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    q0.delete();
    q1.delete();
    expOutValid = 1'b0;
    expOutData  = 8'h00;
    expOutId    = 1'b0;
    expGrantErr = 1'b0;
  endfunction

  // One clock edge of the channel model: pop the granted head (if legal and
  // present), then append accepted pushes; fullness is judged before the pop.
  task automatic modelStep(input logic v0, input logic [7:0] d0,
                           input logic v1, input logic [7:0] d1,
                           input logic [1:0] g);
    bit has0  = q0.size() != 0;
    bit has1  = q1.size() != 0;
    bit room0 = q0.size() < DEPTH;
    bit room1 = q1.size() < DEPTH;
    expGrantErr = (g == 2'b11);
    expOutValid = 1'b0;
    if (g == 2'b01 && has0) begin
      expOutData  = q0.pop_front();
      expOutId    = 1'b0;
      expOutValid = 1'b1;
    end else if (g == 2'b10 && has1) begin
      expOutData  = q1.pop_front();
      expOutId    = 1'b1;
      expOutValid = 1'b1;
    end
    if (v0 && room0) q0.push_back(d0);
    if (v1 && room1) q1.push_back(d1);
  endtask

  // Round-robin arbiter stand-in: on contention, turn 0 favours channel 1.
  function automatic logic [1:0] arbGrant();
    bit r0 = q0.size() != 0;
    bit r1 = q1.size() != 0;
    logic [1:0] g;
    if (r0 && r1) g = arbTurn ? 2'b01 : 2'b10;
    else if (r1)  g = 2'b10;
    else if (r0)  g = 2'b01;
    else          g = 2'b00;
    if (g == 2'b10) arbTurn = 1'b1;
    if (g == 2'b01) arbTurn = 1'b0;
    return g;
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle 1 time unit.
  task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               input logic [1:0] g);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    grants    = g;
    @(posedge clk);
    if (!rst) modelStep(v0, d0, v1, d1, g);
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    grants    = 2'b00;
    arbTurn   = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("requests", 32'(requests), 32'({q1.size() != 0, q0.size() != 0}));
      checkOutput("in0_ready", 32'(in0_ready), 32'(q0.size() < DEPTH));
      checkOutput("in1_ready", 32'(in1_ready), 32'(q1.size() < DEPTH));
      checkOutput("out_valid", 32'(out_valid), 32'(expOutValid));
      checkOutput("out_data", 32'(out_data), 32'(expOutData));
      checkOutput("out_id", 32'(out_id), 32'(expOutId));
      checkOutput("grant_error", 32'(grant_error), 32'(expGrantErr));
    end
  end

  initial begin
    logic [7:0] arbData [4];
    logic       arbId   [4];
    logic [1:0] g;
    int         sel;
    arbData = '{8'h81, 8'h01, 8'h82, 8'h02};
    arbId   = '{1'b1, 1'b0, 1'b1, 1'b0};

    doReset();
    checkEn = 1'b1;
    checkOutput("rst_requests", 32'(requests), 32'h0);
    checkOutput("rst_ready0", 32'(in0_ready), 32'h1);
    checkOutput("rst_ready1", 32'(in1_ready), 32'h1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);

    // Single channel: push A5 then grant it
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 2'b00);
    checkOutput("single_req", 32'(requests), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b01);
    checkOutput("single_valid", 32'(out_valid), 32'h1);
    checkOutput("single_data", 32'(out_data), 32'hA5);
    checkOutput("single_id", 32'(out_id), 32'h0);
    checkOutput("single_req_after", 32'(requests), 32'h0);

    // Asynchronous reset mid-cycle clears the output immediately
    #2;
    rst = 1'b1;
    modelReset();
    arbTurn = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
    grants = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill channel 1 to full, then drain in order
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'(16 + k), 2'b00);
      checkOutput("fill_ready1", 32'(in1_ready), (k == 3) ? 32'h0 : 32'h1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h14, 2'b00);
    checkOutput("full_refuse_ready1", 32'(in1_ready), 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b10);
      checkOutput("drain_data", 32'(out_data), 32'(16 + k));
      checkOutput("drain_id", 32'(out_id), 32'h1);
      checkOutput("drain_ready1", 32'(in1_ready), 32'h1);
    end
    checkOutput("drain_req", 32'(requests), 32'h0);

    // Illegal grant patterns
    applyStimulus(1'b1, 8'h33, 1'b1, 8'h44, 2'b00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b11);
    checkOutput("err_pulse", 32'(grant_error), 32'h1);
    checkOutput("err_no_valid", 32'(out_valid), 32'h0);
    checkOutput("err_req", 32'(requests), 32'h3);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b00);
    checkOutput("err_clear", 32'(grant_error), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b10);
    checkOutput("err_pop1_data", 32'(out_data), 32'h44);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b10);
    checkOutput("empty_grant_valid", 32'(out_valid), 32'h0);
    checkOutput("empty_grant_err", 32'(grant_error), 32'h0);
    checkOutput("empty_grant_req", 32'(requests), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b01);
    checkOutput("err_pop0_data", 32'(out_data), 32'h33);

    // Wrap-around: continuous push and pop on channel 0
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 8'h00, (k > 0) ? 2'b01 : 2'b00);
      checkOutput("wrap_ready0", 32'(in0_ready), 32'h1);
      if (k > 0) checkOutput("wrap_data", 32'(out_data), 32'(k - 1));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 2'b01);
    checkOutput("wrap_last", 32'(out_data), 32'h9);

    // Both channels under the round-robin arbiter
    doReset();
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h81, 2'b00);
    applyStimulus(1'b1, 8'h02, 1'b1, 8'h82, 2'b00);
    for (int k = 0; k < 4; k++) begin
      g = arbGrant();
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, g);
      checkOutput("arb_id", 32'(out_id), 32'(arbId[k]));
      checkOutput("arb_data", 32'(out_data), 32'(arbData[k]));
    end

    // Randomized traffic with occasional resets and illegal grants
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end else begin
        sel = int'($urandom_range(0, 9));
        case (sel)
          0:       g = 2'b11;
          1:       g = 2'b00;
          2:       g = 2'b01;
          3:       g = 2'b10;
          default: g = arbGrant();
        endcase
        applyStimulus($urandom_range(0, 9) < 6, 8'($urandom),
                      $urandom_range(0, 9) < 5, 8'($urandom), g);
      end
    end

    @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
